// File: rtl/demux_1_4_stream_if.sv
// demux_1_4_stream_if: handshake bundle for the 1:4 stream demultiplexer.
// The out_cnt bundle member exists only when DEMUX_STREAM_CNT_EN is defined.
interface demux_1_4_stream_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_bcast;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
`ifdef DEMUX_STREAM_CNT_EN
  logic [4*CNT_W-1:0] out_cnt;
`endif

  // Both widths must be at least one bit.
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("demux_1_4_stream_if: WIDTH and CNT_W must be >= 1");
  end

  // Upstream producer / downstream consumers side.
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
`ifdef DEMUX_STREAM_CNT_EN
    , input out_cnt
`endif
  );

  // Demultiplexer side.
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
`ifdef DEMUX_STREAM_CNT_EN
    , output out_cnt
`endif
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: registered 1:4 valid/ready demultiplexer with unicast
// or atomic broadcast delivery; one-entry output slot per channel.
// Optional feature macro: DEMUX_STREAM_CNT_EN (per-channel saturating
// transfer counters on out_cnt).
module demux_1_4_stream #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  demux_1_4_stream_if.slave bus
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("demux_1_4_stream: WIDTH and CNT_W must be >= 1");
  end

  logic [3:0]         valid_q, valid_d;
  logic [4*WIDTH-1:0] data_q, data_d;
  logic [3:0]         can_take;
  logic [3:0]         target;
  logic [3:0]         load;
  logic [3:0]         pop;
  logic               accept;

  // A slot can take a word when empty or draining on this edge; broadcast
  // needs all four so that delivery is all-or-nothing.
  always_comb begin
    can_take     = ~valid_q | bus.out_ready;
    bus.in_ready = bus.in_bcast ? (&can_take) : can_take[bus.in_sel];
    target       = bus.in_bcast ? 4'b1111 : (4'b0001 << bus.in_sel);
    accept       = bus.in_valid & bus.in_ready;
    load         = accept ? target : '0;
    pop          = valid_q & bus.out_ready;
  end

  // Per-channel next state: load beats pop, so pop+load keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (load[k]) begin
        valid_d[k]                = 1'b1;
        data_d[k*WIDTH +: WIDTH]  = bus.in_data;
      end else if (pop[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  // Output slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

`ifdef DEMUX_STREAM_CNT_EN
  logic [4*CNT_W-1:0] cnt_q, cnt_d;

  // Count output handshakes per channel, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (pop[k] && (cnt_q[k*CNT_W +: CNT_W] != '1)) begin
        cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

  // Transfer counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: table-driven vectors plus per-channel scoreboard
// queues for demux_1_4_stream (WIDTH=4, CNT_W=8).
module tb_demux_1_4_stream;
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_1_4_stream_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  demux_1_4_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         valid;
    logic [W-1:0] data;
    logic [1:0]   sel;
    logic         bcast;
    logic [3:0]   ordy;
    logic         rdy;    // required in_ready for this cycle
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [W-1:0]  sb [4][$];
  logic [CW-1:0] cnt_m [4];
  vec_t tbl [19];

  function automatic vec_t mk(input logic v, input logic [W-1:0] d,
                              input logic [1:0] s, input logic b,
                              input logic [3:0] o, input logic r);
    vec_t t;
    t.valid = v; t.data = d; t.sel = s; t.bcast = b; t.ordy = o; t.rdy = r;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive, sample 1ns later, update model, advance.
  task automatic step(input vec_t v);
    bus.in_valid  = v.valid;
    bus.in_data   = v.data;
    bus.in_sel    = v.sel;
    bus.in_bcast  = v.bcast;
    bus.out_ready = v.ordy;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(v.rdy));
    for (int k = 0; k < 4; k++) begin
      logic ev;
      ev = (sb[k].size() != 0);
      chk($sformatf("out_valid[%0d]", k), 64'(bus.out_valid[k]), 64'(ev));
      if (ev) begin
        chk($sformatf("out_data[%0d]", k), 64'(bus.out_data[k*W +: W]), 64'(sb[k][0]));
      end
`ifdef DEMUX_STREAM_CNT_EN
      chk($sformatf("out_cnt[%0d]", k), 64'(bus.out_cnt[k*CW +: CW]), 64'(cnt_m[k]));
`endif
      if (ev && v.ordy[k]) begin
        void'(sb[k].pop_front());
        if (cnt_m[k] != 8'hFF) cnt_m[k] = cnt_m[k] + 8'd1;
      end
    end
    if (v.valid && v.rdy) begin
      for (int k = 0; k < 4; k++) begin
        if (v.bcast || (v.sel == 2'(k))) sb[k].push_back(v.data);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'h0);
    chk({tag, "_data"},  64'(bus.out_data), 64'h0);
`ifdef DEMUX_STREAM_CNT_EN
    chk({tag, "_cnt"},   64'(bus.out_cnt), 64'h0);
`endif
  endtask

  initial begin
    // unicast, back-to-back
    tbl[0]  = mk(1, 4'hA, 2, 0, 4'b1111, 1);
    tbl[1]  = mk(1, 4'h3, 0, 0, 4'b1111, 1);
    tbl[2]  = mk(1, 4'h5, 3, 0, 4'b1111, 1);
    tbl[3]  = mk(0, 4'h0, 0, 0, 4'b1111, 1);
    // back-pressure on channel 1, channel 2 proceeds, then pop+reload
    tbl[4]  = mk(1, 4'h7, 1, 0, 4'b1101, 1);
    tbl[5]  = mk(1, 4'h8, 1, 0, 4'b1101, 0);
    tbl[6]  = mk(1, 4'h9, 2, 0, 4'b1101, 1);
    tbl[7]  = mk(1, 4'h8, 1, 0, 4'b1111, 1);
    tbl[8]  = mk(0, 4'h0, 0, 0, 4'b1111, 1);
    // broadcast blocked by full channel 2, then atomic load
    tbl[9]  = mk(1, 4'h6, 2, 0, 4'b1011, 1);
    tbl[10] = mk(1, 4'hC, 0, 1, 4'b1011, 0);
    tbl[11] = mk(1, 4'hC, 0, 1, 4'b1111, 1);
    tbl[12] = mk(0, 4'h0, 0, 0, 4'b0000, 0);
    tbl[13] = mk(0, 4'h0, 0, 0, 4'b1111, 1);
    // round-robin at one word per cycle
    tbl[14] = mk(1, 4'h1, 0, 0, 4'b1111, 1);
    tbl[15] = mk(1, 4'h2, 1, 0, 4'b1111, 1);
    tbl[16] = mk(1, 4'h3, 2, 0, 4'b1111, 1);
    tbl[17] = mk(1, 4'h4, 3, 0, 4'b1111, 1);
    tbl[18] = mk(0, 4'h0, 0, 0, 4'b1111, 1);

    for (int k = 0; k < 4; k++) cnt_m[k] = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_sel = '0; bus.in_bcast = 0;
    bus.out_ready = '0;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_cleared("reset");
    chk("reset_in_ready", 64'(bus.in_ready), 64'h1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++) step(tbl[i]);

    // reset between edges with channels 0 and 3 full
    step(mk(1, 4'hE, 0, 0, 4'b0000, 1));
    step(mk(1, 4'hD, 3, 0, 4'b0000, 1));
    #1;
    chk("pre_rst_valid", 64'(bus.out_valid), 64'h9);
    bus.in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("midrst");
    chk("midrst_in_ready", 64'(bus.in_ready), 64'h1);
    for (int k = 0; k < 4; k++) begin
      sb[k].delete();
      cnt_m[k] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DEMUX_STREAM_CNT_EN
    // 300 handshakes on channel 0: counter saturates at 255
    for (int i = 0; i < 300; i++) step(mk(1, 4'(i), 0, 0, 4'b0001, 1));
    step(mk(0, 4'h0, 0, 0, 4'b0001, 1));
    #1;
    chk("cnt0_sat", 64'(bus.out_cnt[0 +: CW]), 64'hFF);
    chk("cnt_others", 64'(bus.out_cnt[CW +: 3*CW]), 64'h0);
`else
    step(mk(1, 4'hF, 1, 0, 4'b1111, 1));
    step(mk(0, 4'h0, 0, 0, 4'b1111, 1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

Registered 1:4 stream demultiplexer: accepts one valid/ready input stream carrying a WIDTH-bit payload and a 2-bit destination select, and delivers each accepted word to exactly one of four output channels, or to all four in broadcast mode. Each channel owns a one-entry output register, so back-pressure on one channel does not block traffic to the others once its slot drains. It is the distribution counterpart of the 4:1 selection path in the combinational-logic set, and sits in front of four independent consumers.

## Interface

- WIDTH, 4, payload width in bits (≥1)
- CNT_W, 8, width of per-channel transfer counters (used only with DEMUX_STREAM_CNT_EN)

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- in_data  input  WIDTH  payload
- in_sel  input  2  destination channel 0..3; ignored when in_bcast=1
- in_bcast  input  1  deliver word to all four channels
- out_valid  output  4  per-channel slot full, bit k = channel k
- out_ready  input  4  per-channel consumer ready
- out_data  output  4*WIDTH  channel k payload at [k*WIDTH +: WIDTH]
- out_cnt  output  4*CNT_W  channel k transfer count at [k*CNT_W +: CNT_W] (DEMUX_STREAM_CNT_EN only)

## Operation

- Input handshake: word accepted when in_valid && in_ready.
- can_k = !out_valid[k] || out_ready[k] (slot empty or draining this cycle).
- in_ready = in_bcast ? (can_0 && can_1 && can_2 && can_3) : can_[in_sel]; combinational, no dependence on in_valid.
- Targets: broadcast → all four; else only channel in_sel.
- Per channel k, at clock edge, priority order:
  - load (accept && k targeted): out_valid[k]=1, out_data[k]=in_data.
  - else pop (out_valid[k] && out_ready[k]): out_valid[k]=0, out_data[k] held.
  - else hold.
- Simultaneous pop and load on one channel: slot stays valid with new data, no bubble, no loss.
- Broadcast is atomic: either all four slots load or none; never partial.
- Untargeted channels unaffected by accept; each drains independently.
- Output stability: while out_valid[k] && !out_ready[k], out_data[k] constant.
- No internal FSM beyond per-channel valid bits; no reordering within a channel.

## Timing

- Reset (rst_n low, async): out_valid=4'b0000, out_data=0, out_cnt=0; in_ready then follows formula (1 when all empty).
- Reset asserted mid-transfer: all buffered words dropped; no output handshake in the reset cycle counts.
- Latency: word accepted at edge N appears on out_valid/out_data after edge N (one cycle).
- Throughput: one word per cycle per channel when its out_ready held 1; sustained round-robin over channels at one word per cycle.
- in_sel/in_bcast/in_data sampled only at the accepting edge.
- Combinational paths: out_ready, in_sel, in_bcast → in_ready. No path from in_* to out_*.

## Configuration

- DEMUX_STREAM_CNT_EN defined: per-channel CNT_W-bit counter increments on each output handshake (out_valid[k] && out_ready[k]), saturates at all-ones (no wrap), cleared only by reset; driven on out_cnt.
- Not defined: no counters synthesized, out_cnt port absent; all other behaviour identical.

## Test plan

- Reset: rst_n=0 then 1 with all inputs 0 → out_valid=0000, out_data=0, in_ready=1, out_cnt=0.
- Unicast: out_ready=1111, send data 4'hA sel 2 → next cycle out_valid=0100, channel 2 data 4'hA; then 4'h3 sel 0, 4'h5 sel 3 back-to-back → one word per cycle, correct channel each.
- Back-pressure: out_ready[1]=0, send 4'h7 sel 1 → slot 1 full; next word sel 1 sees in_ready=0 and stalls; word sel 2 accepted same period; raise out_ready[1] → slot 1 pops and reloads on same edge, no bubble.
- Broadcast: out_ready=1011 with channel 2 full, in_bcast=1 data 4'hC → in_ready=0, no slot changes; set out_ready[2]=1 → all four load 4'hC in one edge.
- Reset mid-operation: fill channels 0 and 3, assert rst_n=0 between edges → out_valid clears immediately, counters 0.
- With DEMUX_STREAM_CNT_EN, CNT_W=8: 300 handshakes on channel 0 → out_cnt[0]=255, others 0.
